// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
// Data and address width reuse the core's INSTRUCTION_SIZE.
package mem_arbiter_pkg;

   localparam int INSTRUCTION_SIZE = 32;
   localparam int STARVE_W         = 4;
   localparam logic [STARVE_W-1:0] STARVE_SAT = 4'd15;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2
   } arb_state_t;

   typedef enum logic {
      OWN_FETCH = 1'b0,
      OWN_DATA  = 1'b1
   } owner_t;

   // Saturating increment so a long data burst cannot wrap the counter.
   function automatic logic [STARVE_W-1:0] starve_inc(input logic [STARVE_W-1:0] cnt);
      return (cnt == STARVE_SAT) ? cnt : cnt + 4'd1;
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, data port and shared-memory port of the arbiter.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface mem_arbiter_if;
   import mem_arbiter_pkg::*;

   logic                        if_req;
   logic [INSTRUCTION_SIZE-1:0] if_addr;
   logic                        if_gnt;
   logic                        if_rvalid;
   logic [INSTRUCTION_SIZE-1:0] if_rdata;

   logic                        d_req;
   logic                        d_we;
   logic [INSTRUCTION_SIZE-1:0] d_addr;
   logic [INSTRUCTION_SIZE-1:0] d_wdata;
   logic [3:0]                  d_be;
   logic                        d_gnt;
   logic                        d_rvalid;
   logic [INSTRUCTION_SIZE-1:0] d_rdata;

   logic                        mem_req;
   logic                        mem_we;
   logic [INSTRUCTION_SIZE-1:0] mem_addr;
   logic [INSTRUCTION_SIZE-1:0] mem_wdata;
   logic [3:0]                  mem_be;
   logic                        mem_ready;
   logic                        mem_rvalid;
   logic [INSTRUCTION_SIZE-1:0] mem_rdata;

   logic                        busy;

   modport slave (
      input  if_req, if_addr,
      output if_gnt, if_rvalid, if_rdata,
      input  d_req, d_we, d_addr, d_wdata, d_be,
      output d_gnt, d_rvalid, d_rdata,
      output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
      input  mem_ready, mem_rvalid, mem_rdata,
      output busy
   );

   modport master (
      output if_req, if_addr,
      input  if_gnt, if_rvalid, if_rdata,
      output d_req, d_we, d_addr, d_wdata, d_be,
      input  d_gnt, d_rvalid, d_rdata,
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
      output mem_ready, mem_rvalid, mem_rdata,
      input  busy
   );

endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single-port memory, one transaction in flight.
// Data has priority; fetch wins after STARVE_MAX consecutive losses.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int STARVE_MAX = 3
) (
   input  logic         clk,
   input  logic         rst,
   mem_arbiter_if.slave bus
);

   localparam logic [STARVE_W-1:0] STARVE_LIM = 4'(STARVE_MAX);

   arb_state_t                  state_r;
   owner_t                      owner_r;
   logic [STARVE_W-1:0]         starve_r;
   logic                        mem_req_r;
   logic                        mem_we_r;
   logic [INSTRUCTION_SIZE-1:0] mem_addr_r;
   logic [INSTRUCTION_SIZE-1:0] mem_wdata_r;
   logic [3:0]                  mem_be_r;
   logic                        if_rvalid_r;
   logic [INSTRUCTION_SIZE-1:0] if_rdata_r;
   logic                        d_rvalid_r;
   logic [INSTRUCTION_SIZE-1:0] d_rdata_r;

   logic idle_s;
   logic both_s;
   logic fetch_win_s;
   logic data_win_s;

   // Winner selection among current requesters
   always_comb begin
      idle_s      = (state_r == ST_IDLE);
      both_s      = bus.if_req & bus.d_req;
      fetch_win_s = bus.if_req & (~bus.d_req | (starve_r == STARVE_LIM));
      data_win_s  = bus.d_req & ~fetch_win_s;
   end

   // Grants are gated by reset so every output is low while rst is asserted
   assign bus.if_gnt = rst & idle_s & fetch_win_s;
   assign bus.d_gnt  = rst & idle_s & data_win_s;

   // Arbitration FSM with registered memory-side and response outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r     <= ST_IDLE;
         owner_r     <= OWN_FETCH;
         starve_r    <= 4'd0;
         mem_req_r   <= 1'b0;
         mem_we_r    <= 1'b0;
         mem_addr_r  <= 32'd0;
         mem_wdata_r <= 32'd0;
         mem_be_r    <= 4'd0;
         if_rvalid_r <= 1'b0;
         if_rdata_r  <= 32'd0;
         d_rvalid_r  <= 1'b0;
         d_rdata_r   <= 32'd0;
      end else begin
         if_rvalid_r <= 1'b0;
         d_rvalid_r  <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (fetch_win_s) begin
                  state_r     <= ST_REQ;
                  owner_r     <= OWN_FETCH;
                  starve_r    <= 4'd0;
                  mem_req_r   <= 1'b1;
                  mem_we_r    <= 1'b0;
                  mem_addr_r  <= bus.if_addr;
                  mem_wdata_r <= 32'd0;
                  mem_be_r    <= 4'hF;
               end else if (data_win_s) begin
                  state_r     <= ST_REQ;
                  owner_r     <= OWN_DATA;
                  mem_req_r   <= 1'b1;
                  mem_we_r    <= bus.d_we;
                  mem_addr_r  <= bus.d_addr;
                  mem_wdata_r <= bus.d_wdata;
                  mem_be_r    <= bus.d_be;
                  if (both_s) begin
                     starve_r <= starve_inc(starve_r);
                  end
               end
            end
            ST_REQ: begin
               if (bus.mem_ready) begin
                  state_r   <= ST_RESP;
                  mem_req_r <= 1'b0;
               end
            end
            ST_RESP: begin
               if (bus.mem_rvalid) begin
                  state_r <= ST_IDLE;
                  if (owner_r == OWN_FETCH) begin
                     if_rvalid_r <= 1'b1;
                     if_rdata_r  <= bus.mem_rdata;
                  end else begin
                     d_rvalid_r <= 1'b1;
                     d_rdata_r  <= mem_we_r ? 32'd0 : bus.mem_rdata;
                  end
               end
            end
            default: begin
               state_r   <= ST_IDLE;
               mem_req_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.mem_req   = mem_req_r;
   assign bus.mem_we    = mem_we_r;
   assign bus.mem_addr  = mem_addr_r;
   assign bus.mem_wdata = mem_wdata_r;
   assign bus.mem_be    = mem_be_r;
   assign bus.if_rvalid = if_rvalid_r;
   assign bus.if_rdata  = if_rdata_r;
   assign bus.d_rvalid  = d_rvalid_r;
   assign bus.d_rdata   = d_rdata_r;
   assign bus.busy      = (state_r != ST_IDLE);

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 3, range 1..15: max consecutive arbitrations fetch may lose to data.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 if_req  input  1  instruction-fetch read request; held with if_addr until if_gnt.
REQ-005 if_addr  input  32  fetch byte address.
REQ-006 if_gnt  output  1  fetch request accepted this cycle.
REQ-007 if_rvalid  output  1  one-cycle pulse, if_rdata valid.
REQ-008 if_rdata  output  32  fetch read data.
REQ-009 d_req  input  1  data request; held with d_we, d_addr, d_wdata, d_be until d_gnt.
REQ-010 d_we  input  1  1 = store, 0 = load.
REQ-011 d_addr  input  32  data byte address.
REQ-012 d_wdata  input  32  store data.
REQ-013 d_be  input  4  store byte enables.
REQ-014 d_gnt  output  1  data request accepted this cycle.
REQ-015 d_rvalid  output  1  one-cycle pulse: load data valid, or store complete.
REQ-016 d_rdata  output  32  load data; 0 for stores.
REQ-017 mem_req  output  1  request to shared single-port memory.
REQ-018 mem_we, mem_addr, mem_wdata, mem_be  output  1/32/32/4  registered attributes of the granted request.
REQ-019 mem_ready  input  1  memory accepts mem_req this cycle.
REQ-020 mem_rvalid  input  1  memory response valid; mem_rdata  input  32  response data.
REQ-021 busy  output  1  high when state is not IDLE.

Function
REQ-022 FSM states IDLE, REQ, RESP; one outstanding transaction maximum.
REQ-023 IDLE: if any request present, select winner, assert its gnt combinationally same cycle, capture attributes and owner, go to REQ.
REQ-024 Selection: data wins when both request, unless starve_cnt == STARVE_MAX, then fetch wins; a sole requester always wins.
REQ-025 starve_cnt: increments (saturating at 15) when both request in IDLE and data wins; clears to 0 when fetch granted; unchanged otherwise.
REQ-026 REQ: mem_req = 1 with captured attributes held stable; on mem_ready go to RESP.
REQ-027 RESP: mem_req = 0; on mem_rvalid register mem_rdata to owner's rdata (0 if store), pulse owner's rvalid next cycle, go to IDLE.
REQ-028 Back-to-back: IDLE may grant in the same cycle the prior rvalid pulse is output.
REQ-029 Minimum latency with mem_ready/mem_rvalid immediate: gnt at cycle t, mem_req at t+1, rvalid at t+3.
REQ-030 gnt never asserted outside IDLE; only one of if_gnt/d_gnt per cycle; only one rvalid per cycle.
REQ-031 mem_rvalid outside RESP and mem_ready outside REQ are ignored.
REQ-032 Requests dropped before gnt are simply not served; no internal queue.

Reset
REQ-033 rst low: state IDLE, starve_cnt 0, all outputs 0 immediately, independent of clk.
REQ-034 Reset mid-transaction discards it; no rvalid is produced for it, late mem_rvalid ignored.

Structure
REQ-035 State encodings and the 32-bit data/address width in RISCV_PKG.vh (reuse INSTRUCTION_SIZE).
REQ-036 Single module; no sub-module required.

Verification
REQ-037 Fetch only, if_addr=0x10, mem_ready/mem_rvalid immediate, mem_rdata=0x00500093 -> if_gnt t, mem_addr=0x10 at t+1, if_rvalid + if_rdata=0x00500093 at t+3.
REQ-038 Both request same cycle, d_addr=0x100 load -> d_gnt, mem_addr=0x100, fetch granted on next IDLE.
REQ-039 Continuous d_req and if_req, STARVE_MAX=3 -> grant order D,D,D,I,D,D,D,I.
REQ-040 Store d_we=1, d_be=0xF, d_wdata=0xDEADBEEF, mem_ready delayed 4 cycles -> mem_req and attributes held stable 5 cycles, d_rvalid with d_rdata=0.
REQ-041 rst low while in RESP, then mem_rvalid -> outputs 0, no rvalid, busy=0, next request served normally.
